// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command bus master.
package uart_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    localparam int unsigned PAYLOAD_BYTES = 4;
    localparam int unsigned LEG_BITS      = 4;
    localparam int unsigned BYTE_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4,
        ST_RESP  = 3'd5
    } cmd_state_t;

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte watchdog: counts enabled idle cycles, pulses expire on the last one.
module cmd_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_c_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // Expire combinationally so the FSM leaves on exactly the TIMEOUT_CYCLES-th idle cycle.
    always_comb begin
        expire_c_o = 1'b0;
        count_d    = count_q + 1'b1;
        if (clear_i || !enable_i) begin
            count_d = '0;
        end else if (count_q == LAST_CNT) begin
            expire_c_o = 1'b1;
            count_d    = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_cmd_bus_master.sv
// UART byte stream to single-beat RGF bus master with byte-serial read responses.
module uart_cmd_bus_master
    import uart_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_LEGS       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_wr_en,
    output logic                  bus_rd_en,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [NUM_LEGS-1:0]   bus_leg,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  err_pulse,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(PAYLOAD_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAYLOAD_BYTES - 1);

    cmd_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  is_write_q, is_write_d;
    logic [LEG_BITS-1:0]   leg_q, leg_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  rx_ready_q, rx_ready_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [NUM_LEGS-1:0]   leg_sel_q, leg_sel_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

    logic                  rx_fire_c;
    logic                  tx_fire_c;
    logic                  tmr_enable_c;
    logic                  tmr_expire_c;
    logic                  leg_valid_c;
    logic                  strobe_c;

    assign rx_fire_c    = rx_valid && rx_ready_q;
    assign tx_fire_c    = tx_valid_q && tx_ready;
    assign tmr_enable_c = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign leg_valid_c  = 32'(leg_q) < NUM_LEGS;

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (rx_fire_c),
        .enable_i   (tmr_enable_c),
        .expire_c_o (tmr_expire_c)
    );

    // Next-state, packet assembly and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        leg_d      = leg_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        strobe_c   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_fire_c) begin
                    if (rx_data == OP_WRITE) begin
                        is_write_d = 1'b1;
                        state_d    = ST_ADDR;
                    end else if (rx_data == OP_READ) begin
                        is_write_d = 1'b0;
                        state_d    = ST_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_fire_c) begin
                    leg_d   = rx_data[7 -: LEG_BITS];
                    addr_d  = rx_data[ADDR_WIDTH-1:0];
                    cnt_d   = '0;
                    state_d = is_write_q ? ST_DATA : ST_READ;
                end else if (tmr_expire_c) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (rx_fire_c) begin
                    wdata_d[BYTE_W*cnt_q +: BYTE_W] = rx_data;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BYTE) begin
                        state_d = ST_WRITE;
                    end
                end else if (tmr_expire_c) begin
                    err_d   = 1'b1;
                    wdata_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_READ: begin
                // Out-of-range legs have nothing selected; force a clean zero response.
                rdata_d = leg_valid_c ? bus_rdata : '0;
                cnt_d   = '0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (tx_fire_c) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BYTE) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        strobe_c   = (state_d == ST_WRITE) || (state_d == ST_READ);
        rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
        tx_valid_d = (state_d == ST_RESP);
        tx_data_d  = (state_d == ST_RESP) ? rdata_d[BYTE_W*cnt_d +: BYTE_W] : 8'h00;
        wr_en_d    = (state_d == ST_WRITE);
        rd_en_d    = (state_d == ST_READ);
        busy_d     = (state_d != ST_IDLE);
        for (int unsigned i = 0; i < NUM_LEGS; i++) begin
            leg_sel_d[i] = strobe_c && (32'(leg_d) == i);
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            leg_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            leg_sel_q  <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            leg_q      <= leg_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            leg_sel_q  <= leg_sel_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign bus_addr  = addr_q;
    assign bus_wr_en = wr_en_q;
    assign bus_rd_en = rd_en_q;
    assign bus_wdata = wdata_q;
    assign bus_leg   = leg_sel_q;
    assign err_pulse = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_bus_master.sv
// Directed self-checking bench for uart_cmd_bus_master.
module tb_uart_cmd_bus_master;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned NL = 4;
    localparam int unsigned TO = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [AW-1:0] bus_addr;
    logic          bus_wr_en;
    logic          bus_rd_en;
    logic [DW-1:0] bus_wdata;
    logic [NL-1:0] bus_leg;
    logic [DW-1:0] bus_rdata;
    logic          err_pulse;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = 0;

    // Monitor state
    int            wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
    int            wr_cyc = 0, rd_cyc = 0, err_cyc = 0, txv_cyc = 0;
    logic [NL-1:0] wr_leg = '0, rd_leg = '0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_wdata = '0;
    logic [7:0]    tx_q[$];
    int            stab_viol = 0, busy_viol = 0;
    logic          prev_txv = 1'b0, prev_txr = 1'b0;
    logic [7:0]    prev_txd = 8'h00;

    uart_cmd_bus_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LEGS(NL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bus_addr(bus_addr), .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en),
        .bus_wdata(bus_wdata), .bus_leg(bus_leg), .bus_rdata(bus_rdata),
        .err_pulse(err_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RGF model: OR of legs, unselected legs drive zero.
    always_comb begin
        bus_rdata = '0;
        if (bus_leg[0]) bus_rdata = (bus_addr == 4'd0) ? 32'h0000_0003 :
                                    (bus_addr == 4'd1) ? 32'hA1B2_C3D4 : 32'h0;
        if (bus_leg[1]) bus_rdata = bus_rdata | 32'h5555_AAAA;
    end

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus_wr_en) begin
            wr_cnt++; wr_leg = bus_leg; wr_addr = bus_addr; wr_wdata = bus_wdata; wr_cyc = cyc;
        end
        if (bus_rd_en) begin
            rd_cnt++; rd_leg = bus_leg; rd_addr = bus_addr; rd_cyc = cyc;
        end
        if (err_pulse) begin
            err_cnt++; err_cyc = cyc;
        end
        if (tx_valid && !prev_txv) txv_cyc = cyc;
        if (prev_txv && !prev_txr && (!tx_valid || tx_data !== prev_txd)) stab_viol++;
        if (tx_valid && !busy) busy_viol++;
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        prev_txv = tx_valid;
        prev_txr = tx_ready;
        prev_txd = tx_data;
    end

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        rx_data = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (rx_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rx_data = 8'h00;
        last_acc = cyc;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL rx_accept byte=%02h got=not_accepted exp=accepted", b);
        end
    endtask

    task automatic wait_tx(input int base, input int n);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk); #1;
            if (tx_q.size() >= base + n) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL tx_wait got=%0d exp=%0d", tx_q.size() - base, n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({rx_ready, tx_valid, bus_wr_en, bus_rd_en, err_pulse, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%06b exp=000000",
                     {rx_ready, tx_valid, bus_wr_en, bus_rd_en, err_pulse, busy});
        end
        checks++;
        if ({tx_data, bus_addr, bus_wdata, bus_leg} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%0h exp=0", {tx_data, bus_addr, bus_wdata, bus_leg});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_rx_ready got=%b exp=1", rx_ready);
        end
    endtask

    task automatic test_write();
        int w0, t0, e0;
        w0 = wr_cnt; t0 = tx_q.size(); e0 = err_cnt;
        send_byte(8'h57); send_byte(8'h10);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        idle(10);
        checks++;
        if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL wr_count got=%0d exp=1", wr_cnt - w0); end
        checks++;
        if (wr_leg !== 4'b0010) begin failures++; $display("FAIL wr_leg got=%b exp=0010", wr_leg); end
        checks++;
        if (wr_addr !== 4'h0) begin failures++; $display("FAIL wr_addr got=%h exp=0", wr_addr); end
        checks++;
        if (wr_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_wdata got=%h exp=deadbeef", wr_wdata); end
        checks++;
        if (wr_cyc !== last_acc) begin failures++; $display("FAIL wr_timing got=%0d exp=%0d", wr_cyc, last_acc); end
        checks++;
        if (tx_q.size() - t0 !== 0 || err_cnt - e0 !== 0) begin
            failures++; $display("FAIL wr_side_effects got=tx%0d/err%0d exp=tx0/err0", tx_q.size() - t0, err_cnt - e0);
        end
    endtask

    task automatic test_read();
        int r0, t0;
        logic [31:0] got;
        r0 = rd_cnt; t0 = tx_q.size();
        send_byte(8'h52); send_byte(8'h00);
        wait_tx(t0, 4);
        idle(5);
        checks++;
        if (rd_cnt - r0 !== 1) begin failures++; $display("FAIL rd_count got=%0d exp=1", rd_cnt - r0); end
        checks++;
        if (rd_leg !== 4'b0001) begin failures++; $display("FAIL rd_leg got=%b exp=0001", rd_leg); end
        checks++;
        if (rd_cyc !== last_acc) begin failures++; $display("FAIL rd_timing got=%0d exp=%0d", rd_cyc, last_acc); end
        checks++;
        if (txv_cyc !== rd_cyc + 1) begin failures++; $display("FAIL tx_first_timing got=%0d exp=%0d", txv_cyc, rd_cyc + 1); end
        got = {tx_q[t0+3], tx_q[t0+2], tx_q[t0+1], tx_q[t0]};
        checks++;
        if (got !== 32'h0000_0003 || tx_q.size() - t0 !== 4) begin
            failures++; $display("FAIL rd_bytes got=%h n=%0d exp=00000003 n=4", got, tx_q.size() - t0);
        end
    endtask

    task automatic test_backpressure();
        int t0, s0, b0;
        logic [31:0] got;
        logic busy_before_last;
        t0 = tx_q.size(); s0 = stab_viol; b0 = busy_viol;
        busy_before_last = 1'b0;
        tx_ready = 1'b0;
        send_byte(8'h52); send_byte(8'h00);
        for (int k = 0; k < 4; k++) begin
            idle(10);
            if (k == 3) busy_before_last = busy;
            tx_ready = 1'b1;
            @(posedge clk); #1;
            tx_ready = 1'b0;
        end
        checks++;
        if (busy_before_last !== 1'b1) begin failures++; $display("FAIL bp_busy_held got=%b exp=1", busy_before_last); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy_drop got=%b exp=0", busy); end
        idle(20);
        tx_ready = 1'b1;
        checks++;
        if (tx_q.size() - t0 !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", tx_q.size() - t0); end
        got = {tx_q[t0+3], tx_q[t0+2], tx_q[t0+1], tx_q[t0]};
        checks++;
        if (got !== 32'h0000_0003) begin failures++; $display("FAIL bp_bytes got=%h exp=00000003", got); end
        checks++;
        if (stab_viol - s0 !== 0 || busy_viol - b0 !== 0) begin
            failures++; $display("FAIL bp_stability got=%0d/%0d exp=0/0", stab_viol - s0, busy_viol - b0);
        end
    endtask

    task automatic test_bad_opcode_and_leg();
        int e0, t0;
        logic [31:0] got;
        e0 = err_cnt;
        send_byte(8'h41);
        idle(3);
        checks++;
        if (err_cnt - e0 !== 1 || err_cyc !== last_acc) begin
            failures++; $display("FAIL bad_op_err got=%0d@%0d exp=1@%0d", err_cnt - e0, err_cyc, last_acc);
        end
        checks++;
        if (busy !== 1'b0 || rx_ready !== 1'b1) begin failures++; $display("FAIL bad_op_idle got=%b%b exp=01", busy, rx_ready); end
        e0 = err_cnt; t0 = tx_q.size();
        send_byte(8'h52); send_byte(8'h70);
        wait_tx(t0, 4);
        idle(5);
        checks++;
        if (rd_leg !== 4'b0000 || rd_cyc !== last_acc) begin
            failures++; $display("FAIL bad_leg_sel got=%b@%0d exp=0000@%0d", rd_leg, rd_cyc, last_acc);
        end
        got = {tx_q[t0+3], tx_q[t0+2], tx_q[t0+1], tx_q[t0]};
        checks++;
        if (got !== 32'h0) begin failures++; $display("FAIL bad_leg_bytes got=%h exp=00000000", got); end
        checks++;
        if (err_cnt - e0 !== 0) begin failures++; $display("FAIL bad_leg_err got=%0d exp=0", err_cnt - e0); end
    endtask

    task automatic test_timeout();
        int e0, w0;
        e0 = err_cnt; w0 = wr_cnt;
        send_byte(8'h57); send_byte(8'h03); send_byte(8'hAA);
        idle(45);
        checks++;
        if (err_cnt - e0 !== 0) begin failures++; $display("FAIL to_early got=%0d exp=0", err_cnt - e0); end
        idle(15);
        checks++;
        if (err_cnt - e0 !== 1) begin failures++; $display("FAIL to_err_count got=%0d exp=1", err_cnt - e0); end
        checks++;
        if (err_cyc !== last_acc + int'(TO)) begin failures++; $display("FAIL to_err_timing got=%0d exp=%0d", err_cyc, last_acc + int'(TO)); end
        checks++;
        if (wr_cnt - w0 !== 0 || busy !== 1'b0) begin failures++; $display("FAIL to_no_strobe got=%0d/%b exp=0/0", wr_cnt - w0, busy); end
        send_byte(8'h57); send_byte(8'h21);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        idle(5);
        checks++;
        if (wr_cnt - w0 !== 1 || wr_wdata !== 32'h4433_2211 || wr_leg !== 4'b0100 || wr_addr !== 4'h1) begin
            failures++; $display("FAIL to_recover_write got=%0d/%h/%b/%h exp=1/44332211/0100/1",
                                 wr_cnt - w0, wr_wdata, wr_leg, wr_addr);
        end
    endtask

    task automatic test_reset_mid_packet();
        int w0, t0;
        logic [31:0] got;
        w0 = wr_cnt; t0 = tx_q.size();
        send_byte(8'h57); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({rx_ready, tx_valid, bus_wr_en, bus_rd_en, err_pulse, busy, bus_leg} !== '0 || bus_wdata !== '0) begin
            failures++; $display("FAIL rst_mid_outputs got=%0h/%h exp=0/0",
                                 {rx_ready, tx_valid, bus_wr_en, bus_rd_en, err_pulse, busy, bus_leg}, bus_wdata);
        end
        idle(2);
        rst_n = 1'b1;
        idle(20);
        checks++;
        if (wr_cnt - w0 !== 0 || tx_q.size() - t0 !== 0) begin
            failures++; $display("FAIL rst_mid_no_strobe got=%0d/%0d exp=0/0", wr_cnt - w0, tx_q.size() - t0);
        end
        send_byte(8'h52); send_byte(8'h01);
        wait_tx(t0, 4);
        got = {tx_q[t0+3], tx_q[t0+2], tx_q[t0+1], tx_q[t0]};
        checks++;
        if (got !== 32'hA1B2_C3D4 || rd_leg !== 4'b0001 || rd_addr !== 4'h1) begin
            failures++; $display("FAIL rst_mid_read got=%h/%b/%h exp=a1b2c3d4/0001/1", got, rd_leg, rd_addr);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_bad_opcode_and_leg();
        test_timeout();
        test_reset_mid_packet();
        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_bus_master.md
Name: uart_cmd_bus_master

Overview:
- Converts the UART receive byte stream into single-beat register-bus transactions on the RGF bus: addr, wr_en, rd_en, wdata, per-leg select, rdata.
- Sits between the UART RX/TX byte interfaces and all RGF instances, including the system RGF.
- Read responses go back out as bytes on the UART TX stream.
- Malformed or stalled packets are dropped and flagged.

Parameters:
ADDR_WIDTH, 4, register address width inside one RGF leg
DATA_WIDTH, 32, bus data width; fixed at 32 (4 payload bytes)
NUM_LEGS, 4, number of RGF legs; one select bit each
TIMEOUT_CYCLES, 100000, maximum idle clocks between bytes of one packet

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rx_data  in  8  received byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  block accepts byte (transfer = valid & ready)
tx_data  out  8  response byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART TX accepts byte
bus_addr  out  ADDR_WIDTH  register address
bus_wr_en  out  1  write strobe, 1-cycle pulse
bus_rd_en  out  1  read strobe, 1-cycle pulse
bus_wdata  out  DATA_WIDTH  write data
bus_leg  out  NUM_LEGS  one-hot leg select (addr_decoder_leg of each RGF)
bus_rdata  in  DATA_WIDTH  OR of all RGF rdata outputs (unselected RGFs drive 0)
err_pulse  out  1  1-cycle pulse on a dropped packet
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, rx_ready=0 during reset, state IDLE, bus_wdata=0, timeout counter cleared.
- Packet format, all bytes LSB-first:
  - byte0 opcode: 0x57 'W' or 0x52 'R'.
  - byte1 address: [7:4] leg index, [ADDR_WIDTH-1:0] register address.
  - Write only: 4 data bytes, wdata[7:0] first.
- States: IDLE, ADDR, DATA, WRITE, READ, RESP.
- IDLE: rx_ready=1.
  - 'W' or 'R' -> ADDR.
  - Any other byte -> stay IDLE, err_pulse=1 next cycle.
- ADDR: rx_ready=1. On byte: latch leg and address.
  - 'W' -> DATA with byte count=0.
  - 'R' -> READ.
- DATA: rx_ready=1. Shift each byte into wdata[8*cnt +: 8]. The 4th byte -> WRITE.
- WRITE (one cycle): rx_ready=0, bus_wr_en=1, bus_leg=onehot(leg) -> IDLE.
  - wr_en appears the cycle after the 4th data-byte handshake.
- READ (one cycle): rx_ready=0, bus_rd_en=1, bus_leg=onehot(leg).
  - Capture bus_rdata at this clock edge (RGF read is combinational), then -> RESP with count=0.
- RESP: tx_valid=1, tx_data=rdata_q[8*cnt +: 8].
  - Advance cnt on tx_valid & tx_ready.
  - After the 4th handshake -> IDLE. tx_valid stays high until each byte is accepted.
  - The first tx byte is valid the cycle after bus_rd_en.
- bus_addr and bus_leg are held stable from the ADDR byte until the strobe cycle. bus_leg=0 outside WRITE/READ.
- Leg index >= NUM_LEGS:
  - bus_leg=0; the strobe is still issued with no leg selected.
  - A read returns 0x00000000 (four 0x00 bytes).
  - No error is flagged.
- Inter-byte timeout:
  - Counter is cleared on every accepted rx byte and counts while in ADDR or DATA.
  - Reaching TIMEOUT_CYCLES: -> IDLE, err_pulse=1, partial wdata discarded, no strobe.
  - The counter is inactive in IDLE, READ and RESP.
- rx bytes arriving during WRITE, READ or RESP are not accepted (rx_ready=0). Upstream must buffer them.
- Reset mid-packet: immediate return to IDLE. No strobe or tx byte is issued afterwards for that packet.

Decomposition:
- Package uart_cmd_pkg holds:
  - opcode constants OP_WRITE=8'h57, OP_READ=8'h52.
  - state enum cmd_state_t.
  - constants PAYLOAD_BYTES=4 and LEG_BITS=4.
- Sub-module cmd_timeout_timer:
  - Inputs: clear, enable. Output: expire pulse.
  - Counter width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Write: rx 57 10 EF BE AD DE -> one bus_wr_en cycle with bus_leg=0010, bus_addr=0, bus_wdata=DEADBEEF, on the cycle after the last byte; no tx bytes.
- Read: bus_rdata model returns 00000003 for leg0 addr0; rx 52 00 -> bus_rd_en 1 cycle, bus_leg=0001; tx 03 00 00 00 in order.
- TX backpressure: same read with tx_ready low for 10 cycles between each byte -> tx_data held stable while valid; exactly 4 bytes sent; busy high until the last handshake.
- Bad opcode and invalid leg: rx 41 -> err_pulse, state IDLE. Then rx 52 70 (leg 7, NUM_LEGS=4) -> bus_leg=0000, tx 00 00 00 00, no err_pulse.
- Timeout (TIMEOUT_CYCLES=50): rx 57 03 AA then idle 50 cycles -> err_pulse once, no bus_wr_en. A following full write packet then executes normally.
- Reset mid-packet: rx 57 01 11 22, assert rst_n=0 for 2 cycles, release -> outputs 0, no wr_en. rx 52 01 then completes a normal read.
